// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage register bank: register index width,
// the MIPS nop encoding, the per-boundary bundle and its bubble value.
package pipe_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CTRL_W = 10;

    localparam logic [PIPE_DATA_W-1:0] NOP_IR = 32'h0000_0000;

    typedef struct packed {
        logic                   valid;
        logic [PIPE_DATA_W-1:0] pc;
        logic [PIPE_DATA_W-1:0] ir;
        logic [PIPE_CTRL_W-1:0] ctrl;
        logic [REG_IDX_W-1:0]   dst;
        logic                   wen;
        logic                   load;
    } stage_t;

    // An empty slot: invalid, nop instruction, every side effect disabled.
    function automatic stage_t bubble_stage();
        stage_t b;
        b.valid = 1'b0;
        b.pc    = {PIPE_DATA_W{1'b0}};
        b.ir    = NOP_IR;
        b.ctrl  = {PIPE_CTRL_W{1'b0}};
        b.dst   = {REG_IDX_W{1'b0}};
        b.wen   = 1'b0;
        b.load  = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline boundary. hold freezes the slot and outranks kill; kill or an
// invalid input loads a bubble so stale payload is never captured.
module pipe_stage_reg
    import pipe_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   hold,
    input  logic   kill,
    input  stage_t d,
    output stage_t q
);

    stage_t q_r;

    // Boundary register: reset > hold > kill/invalid > load.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r <= bubble_stage();
        end else if (hold) begin
            q_r <= q_r;
        end else if (kill || !d.valid) begin
            q_r <= bubble_stage();
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipeline_regbank.sv
// Chain of STAGES boundaries with load-use hazard detection, flush, external
// stall and an optional retire counter (enabled by PIPE_RETIRE_CNT_EN).
module pipeline_regbank
    import pipe_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]          in_ir,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [REG_IDX_W-1:0]       in_dst,
    input  logic                       in_wen,
    input  logic                       in_load,
    input  logic [REG_IDX_W-1:0]       in_src_a,
    input  logic [REG_IDX_W-1:0]       in_src_b,
    input  logic                       in_use_a,
    input  logic                       in_use_b,
    input  logic                       flush_req,
    input  logic                       ext_stall,
    output logic                       stall_out,
    output logic [STAGES-1:0]          st_valid,
    output logic [STAGES*DATA_W-1:0]   st_pc,
    output logic [STAGES*DATA_W-1:0]   st_ir,
    output logic [STAGES*CTRL_W-1:0]   st_ctrl,
    output logic [STAGES*REG_IDX_W-1:0] st_dst,
    output logic [STAGES-1:0]          st_wen,
    output logic [STAGES-1:0]          st_load,
    output logic [31:0]                retire_count
);

    stage_t stage_in_s;
    stage_t stage_q_s [STAGES];
    logic   haz_s;
    logic   hit_a_s;
    logic   hit_b_s;
    logic   kill0_s;

    // Load-use detection against the load currently sitting in stage 0.
    always_comb begin
        hit_a_s = in_use_a && (in_src_a == stage_q_s[0].dst);
        hit_b_s = in_use_b && (in_src_b == stage_q_s[0].dst);
        haz_s   = in_valid && stage_q_s[0].valid && stage_q_s[0].load &&
                  stage_q_s[0].wen && (stage_q_s[0].dst != 5'd0) &&
                  (hit_a_s || hit_b_s);
    end

    assign stall_out = ext_stall | (haz_s & ~flush_req);
    assign kill0_s   = flush_req | haz_s;

    // Decode-side bundle entering stage 0.
    always_comb begin
        stage_in_s       = bubble_stage();
        stage_in_s.valid = in_valid;
        stage_in_s.pc    = PIPE_DATA_W'(in_pc);
        stage_in_s.ir    = PIPE_DATA_W'(in_ir);
        stage_in_s.ctrl  = PIPE_CTRL_W'(in_ctrl);
        stage_in_s.dst   = in_dst;
        stage_in_s.wen   = in_wen;
        stage_in_s.load  = in_load;
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            if (g == 0) begin : g_head
                pipe_stage_reg u_reg (
                    .clock (clock),
                    .reset (reset),
                    .hold  (ext_stall),
                    .kill  (kill0_s),
                    .d     (stage_in_s),
                    .q     (stage_q_s[g])
                );
            end else begin : g_body
                pipe_stage_reg u_reg (
                    .clock (clock),
                    .reset (reset),
                    .hold  (ext_stall),
                    .kill  (1'b0),
                    .d     (stage_q_s[g-1]),
                    .q     (stage_q_s[g])
                );
            end
            assign st_valid[g]                         = stage_q_s[g].valid;
            assign st_pc[g*DATA_W +: DATA_W]           = DATA_W'(stage_q_s[g].pc);
            assign st_ir[g*DATA_W +: DATA_W]           = DATA_W'(stage_q_s[g].ir);
            assign st_ctrl[g*CTRL_W +: CTRL_W]         = CTRL_W'(stage_q_s[g].ctrl);
            assign st_dst[g*REG_IDX_W +: REG_IDX_W]    = stage_q_s[g].dst;
            assign st_wen[g]                           = stage_q_s[g].wen;
            assign st_load[g]                          = stage_q_s[g].load;
        end
    endgenerate

`ifdef PIPE_RETIRE_CNT_EN
    logic [31:0] retire_cnt_r;

    // Count instructions leaving the last stage; wraps silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            retire_cnt_r <= 32'd0;
        end else if (!ext_stall && stage_q_s[STAGES-1].valid) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign retire_count = retire_cnt_r;
`else
    assign retire_count = 32'd0;
`endif

endmodule
